// File: rtl/bram_qr_arbiter_pkg.sv
// bram_qr_arbiter_pkg: shared widths, defaults and reader IDs for the query BRAM arbiter
package bram_qr_arbiter_pkg;
    localparam int RD_ID_W = 1;
    localparam logic [RD_ID_W-1:0] RD0_ID = 1'b0;
    localparam logic [RD_ID_W-1:0] RD1_ID = 1'b1;
    localparam int QR_ADDR_WIDTH = 4;
    localparam int QR_DATA_WIDTH = 8;
    localparam int QR_WR_BURST_MAX = 4;
endpackage

// File: rtl/bram_qr_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter remembering the last served reader
module rr_arb2
    import bram_qr_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    logic [RD_ID_W-1:0] r_last;

    // grant a lone requester directly; on contention grant the one not served last
    always_comb o_gnt = !i_en ? 2'b00 : (&i_req) ? ((r_last == RD0_ID) ? 2'b10 : 2'b01) : i_req;

    // reset to reader 1 so reader 0 wins the first contended grant
    always_ff @(posedge clk or posedge rst)
        if (rst) r_last <= RD1_ID;
        else if (|o_gnt) r_last <= o_gnt[1] ? RD1_ID : RD0_ID;
endmodule

// File: rtl/bram_qr_arbiter.sv
// bram_qr_arbiter: shares one single-port BRAM between a writer and two round-robin readers
module bram_qr_arbiter
    import bram_qr_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = QR_ADDR_WIDTH,
    parameter int DATA_WIDTH   = QR_DATA_WIDTH,
    parameter int WR_BURST_MAX = QR_WR_BURST_MAX
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd0_valid,
    output logic                  o_rd0_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd0_addr,
    input  logic                  i_rd1_valid,
    output logic                  o_rd1_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd1_addr,
    output logic                  o_rsp_valid,
    output logic [RD_ID_W-1:0]    o_rsp_id,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic                  o_bram_write_en,
    output logic [DATA_WIDTH-1:0] o_bram_data_in,
    input  logic [DATA_WIDTH-1:0] i_bram_data_out
);
    localparam logic [7:0] LP_MAX = 8'(WR_BURST_MAX);

    logic [7:0] r_streak;
    logic       w_any_rd;
    logic       w_wr_gnt;
    logic [1:0] w_rd_gnt;

    // writes win unless a reader has already waited out a full write burst
    always_comb begin
        w_any_rd = i_rd0_valid | i_rd1_valid;
        w_wr_gnt = !rst & i_wr_valid & !(w_any_rd & (r_streak == LP_MAX));
    end

    rr_arb2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .i_en  (!rst & !w_wr_gnt),
        .i_req ({i_rd1_valid, i_rd0_valid}),
        .o_gnt (w_rd_gnt)
    );

    // route the granted requester onto the BRAM port
    always_comb begin
        o_wr_ready      = w_wr_gnt;
        o_rd0_ready     = w_rd_gnt[0];
        o_rd1_ready     = w_rd_gnt[1];
        o_bram_write_en = w_wr_gnt;
        o_bram_data_in  = i_wr_data;
        o_bram_addr     = w_rd_gnt[0] ? i_rd0_addr : w_rd_gnt[1] ? i_rd1_addr : i_wr_addr;
        o_rsp_data      = i_bram_data_out;
    end

    // count writes granted over a waiting reader; anything else restarts the count
    always_ff @(posedge clk or posedge rst)
        if (rst) r_streak <= '0;
        else r_streak <= (w_wr_gnt & w_any_rd) ? r_streak + 8'd1 : 8'd0;

    // tag the BRAM output one cycle after a read grant
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            o_rsp_valid <= 1'b0;
            o_rsp_id    <= RD0_ID;
        end else begin
            o_rsp_valid <= |w_rd_gnt;
            o_rsp_id    <= w_rd_gnt[1] ? RD1_ID : RD0_ID;
        end
endmodule

// File: doc/bram_qr_arbiter.md
Name: bram_qr_arbiter

Overview:
- Shares one single-port query/reference BRAM (1-cycle read latency, read-before-write) between one writer (sequence loader) and two readers (e.g. two PE array feeders).
- Valid/ready request handshakes per requester; one BRAM access per cycle; read data returned with requester ID one cycle after grant.
- Writes take priority over reads, but a streak counter bounds write bursts so reads cannot starve. The two readers are served round-robin.
- Sits between the loader/PE control logic and the BRAM instance.

Parameters:
- ADDR_WIDTH, 4, BRAM address width; must match the BRAM instance.
- DATA_WIDTH, 8, BRAM data width; must match the BRAM instance.
- WR_BURST_MAX, 4, max consecutive write grants while any read is pending; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write grant this cycle (combinational).
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd0_valid  in  1  reader 0 request.
- rd0_ready  out  1  reader 0 grant (combinational).
- rd0_addr  in  ADDR_WIDTH  reader 0 address.
- rd1_valid  in  1  reader 1 request.
- rd1_ready  out  1  reader 1 grant (combinational).
- rd1_addr  in  ADDR_WIDTH  reader 1 address.
- rsp_valid  out  1  read data valid (registered).
- rsp_id  out  1  requester of the current response: 0 = rd0, 1 = rd1 (registered).
- rsp_data  out  DATA_WIDTH  read data; passes straight through from bram_data_out.
- bram_addr  out  ADDR_WIDTH  to BRAM addr (combinational mux).
- bram_write_en  out  1  to BRAM write_en; equals wr_valid & wr_ready.
- bram_data_in  out  DATA_WIDTH  to BRAM data_in; equals wr_data.
- bram_data_out  in  DATA_WIDTH  from BRAM data_out.

Behaviour:
- Reset values (async, immediate on rst):
  - rsp_valid=0, rsp_id=0.
  - wr_streak=0; rr_last=1, so rd0 wins the first contended read.
  - All readys=0 while rst is high.
- At most one grant per cycle. A transfer occurs when valid & ready are both high in the same cycle. Grant depends only on the current valids and internal state; no valid→ready→valid loop.
- Grant decision, priority order:
  - (a) If wr_valid and not (any rd valid and wr_streak==WR_BURST_MAX): grant the write.
  - (b) Else if exactly one reader is valid: grant it.
  - (c) Else if both readers are valid: grant the reader other than rr_last.
  - (d) Else: no grant. bram_addr = wr_addr, bram_write_en=0.
- bram_addr follows the granted requester's address.
- wr_streak update:
  - Write granted while any reader valid: increment, saturating at WR_BURST_MAX.
  - Read granted, or cycle without a write grant: clear to 0.
  - Write granted with no reader valid: hold at 0.
- rr_last updates to the granted reader's ID on every read grant, including the uncontended case.
- Response timing: read granted in cycle N → rsp_valid=1 and rsp_id=ID in cycle N+1, with rsp_data = BRAM contents at the address as of edge N.
  - No response backpressure; the consumer must accept every response.
  - Back-to-back reads give a response every cycle.
- Read-after-write to the same address:
  - Write granted in cycle N, read granted in cycle N+1 → the read returns the new data.
  - A write and a read can never be granted in the same cycle.
- Requesters may drop valid without a grant; no state is kept for an ungranted request.
- Reset mid-operation: a response in flight is discarded (rsp_valid forced to 0). Any pending BRAM write is lost if rst asserts before the edge.

Decomposition:
- Shared package holds:
  - RD_ID_W=1 and ID constants RD0_ID/RD1_ID.
  - Default widths for the query BRAM (ADDR_WIDTH/DATA_WIDTH).
  - The WR_BURST_MAX default.
- One natural sub-module: rr_arb2, the two-input round-robin arbiter with its rr_last register. Grant mux, streak counter and response pipeline stay in the top.

Test Plan:
- Write-then-read: write addr 3 = 0xA5; next cycle rd0 reads addr 3 → exactly one cycle later rsp_valid=1, rsp_id=0, rsp_data=0xA5.
- Read contention: rd0 and rd1 valid continuously, addrs 1 and 2 preloaded with 0x11 and 0x22 → grants alternate rd0, rd1, rd0, ...; responses 0x11 (id 0), 0x22 (id 1), ... every cycle.
- Starvation bound: WR_BURST_MAX=4, wr_valid held high and rd1_valid high from cycle 0 → 4 write grants, then rd1 granted in cycle 4, then writes resume. Pattern repeats 4:1.
- Write with no readers: wr_valid high for 10 cycles, no readers → 10 consecutive write grants, wr_streak stays 0; a read arriving in cycle 10 waits for at most 4 further writes.
- Reset mid-flight: rd0 granted in cycle N, rst asserted asynchronously during cycle N+1 → rsp_valid drops immediately; after release the first contended read grant goes to rd0.
- Idle/drop: rd1_valid pulses for one cycle while a write holds priority (streak<max) → no rd1 grant and no response; bram_write_en=1 only in cycles where wr_valid is high.
